// File: rtl/led_seq_pkg.sv
// Shared constants and helpers for the LED button sequencer.
// Mode encoding, fixed patterns and the per-mode LED mapping.
package led_seq_pkg;

  localparam int LED_W = 6;
  localparam int BTN_W = 3;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [LED_W-1:0] STATIC_PATTERN = 6'b101010;
  localparam logic [LED_W-1:0] CHASE_SEED     = 6'b000001;

  function automatic logic [LED_W-1:0] led_pattern(
    input logic [1:0]       m,
    input logic [LED_W-1:0] pos,
    input logic             phase
  );
    logic [LED_W-1:0] p;
    p = '0;
    unique case (m)
      MODE_OFF:    p = '0;
      MODE_STATIC: p = STATIC_PATTERN;
      MODE_CHASE:  p = pos;
      MODE_BLINK:  p = {LED_W{phase}};
      default:     p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [LED_W-1:0] rotate(
    input logic [LED_W-1:0] pos,
    input logic             dir
  );
    return (dir == DIR_RIGHT) ? {pos[0], pos[LED_W-1:1]}
                              : {pos[LED_W-2:0], pos[LED_W-1]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-level debouncer and press detector
// for one raw, asynchronous, active-high button.
module btn_debounce
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2)
                    ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CLAST) begin
          level <= sync2;
          cnt   <= '0;
          // only a settled rising level counts as a press
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_button_sequencer.sv
// Button-driven LED sequencer: debounced press events drive a mode FSM,
// a step prescaler and the static / chase / blink pattern generator.
module led_button_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int STEP_CYCLES     = 1200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BTN_W-1:0] btn,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             step_tick
);

  localparam int PW = (STEP_CYCLES > 2)
                    ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] PLAST = PW'(STEP_CYCLES - 1);

  logic [BTN_W-1:0] level;
  logic [BTN_W-1:0] press;
  logic [BTN_W-1:0] ev;

  for (genvar i = 0; i < BTN_W; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (btn[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  assign ev = press & level;

  logic             running;
  logic             dir;
  logic [LED_W-1:0] pos;
  logic             phase;
  logic [PW-1:0]    presc;

  logic [1:0]       mode_n;
  logic             running_n;
  logic             dir_n;
  logic [LED_W-1:0] pos_n;
  logic             phase_n;
  logic [PW-1:0]    presc_n;
  logic             tick_n;
  logic             active;

  assign active = running & mode[1];

  always_comb begin
    mode_n    = mode;
    running_n = running ^ ev[1];
    dir_n     = dir ^ ev[2];
    pos_n     = pos;
    phase_n   = phase;
    presc_n   = presc;
    tick_n    = 1'b0;
    if (ev[0]) begin
      // a mode change restarts the pattern from its seed
      mode_n  = mode + 2'd1;
      pos_n   = CHASE_SEED;
      phase_n = 1'b1;
      presc_n = '0;
    end else if (!mode[1]) begin
      presc_n = '0;
    end else if (active) begin
      if (presc == PLAST) begin
        presc_n = '0;
        tick_n  = 1'b1;
        if (mode == MODE_CHASE) begin
          pos_n = rotate(pos, dir);
        end else begin
          phase_n = ~phase;
        end
      end else begin
        presc_n = presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode      <= MODE_OFF;
      running   <= 1'b1;
      dir       <= DIR_LEFT;
      pos       <= CHASE_SEED;
      phase     <= 1'b1;
      presc     <= '0;
      step_tick <= 1'b0;
      led       <= '0;
    end else begin
      mode      <= mode_n;
      running   <= running_n;
      dir       <= dir_n;
      pos       <= pos_n;
      phase     <= phase_n;
      presc     <= presc_n;
      step_tick <= tick_n;
      led       <= led_pattern(mode_n, pos_n, phase_n);
    end
  end

endmodule

// File: tb/tb_led_button_sequencer.sv
// Scoreboard bench for led_button_sequencer with DEBOUNCE_CYCLES=4,
// STEP_CYCLES=5; expectations are keyed to rising-edge counts.
module tb_led_button_sequencer;

  localparam int DB = 4;
  localparam int ST = 5;
  localparam logic [2:0] ALL = 3'b111;
  localparam logic [2:0] MO  = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic [5:0] led;
  logic [1:0] mode;
  logic       step_tick;

  led_button_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .STEP_CYCLES    (ST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .led      (led),
    .mode     (mode),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    int         cyc;
    logic [1:0] m;
    logic [5:0] l;
    logic       t;
    logic [2:0] mk;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic void push(input int c, input logic [1:0] m,
                               input logic [5:0] l, input logic t,
                               input logic [2:0] mk, input string nm);
    exp_t x;
    int   i;
    x.cyc = c; x.m = m; x.l = l; x.t = t; x.mk = mk; x.nm = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, x);
  endfunction

  always @(negedge clk) begin : mon
    exp_t x;
    logic ok;
    while (sb.size() > 0 && sb[0].cyc <= edges) begin
      x = sb.pop_front();
      checks++;
      ok = (x.cyc == edges)
        && (!x.mk[0] || mode == x.m)
        && (!x.mk[1] || led == x.l)
        && (!x.mk[2] || step_tick == x.t);
      if (!ok) begin
        failures++;
        $display("FAIL %s cyc=%0d/%0d mode=%0d exp %0d led=%b exp %b tick=%b exp %b",
                 x.nm, edges, x.cyc, mode, x.m, led, x.l, step_tick, x.t);
      end
    end
  end

  task automatic wait_until(input int c);
    while (edges < c) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] m);
    btn = m;
    repeat (10) @(negedge clk);
    btn = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  int hi[10] = '{1, 2, 3, 1, 3, 2, 3, 1, 2, 3};
  int lo[10] = '{1, 1, 1, 2, 2, 3, 1, 1, 2, 1};

  initial begin
    int e, c, b, t, n, len;
    rst = 1'b1;
    btn = 3'b111;
    push(1, 2'd0, 6'd0, 1'b0, ALL, "reset_c1");
    push(2, 2'd0, 6'd0, 1'b0, ALL, "reset_c2");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 3; k <= 14; k++)
      push(k, 2'd0, 6'd0, 1'b0, ALL, "post_rst_quiet");
    @(negedge clk);
    btn = 3'b000;
    repeat (12) @(negedge clk);

    // mode cycling 1,2,3,0
    e = edges + 7;
    push(e - 1, 2'd0, 6'd0, 1'b0, ALL, "pre_static");
    push(e, 2'd1, 6'b101010, 1'b0, ALL, "static_latency");
    press(3'b001);
    e = edges + 7;
    push(e - 1, 2'd1, 6'b101010, 1'b0, ALL, "pre_chase");
    push(e, 2'd2, 6'b000001, 1'b0, ALL, "chase_entry");
    push(e + 5, 2'd2, 6'b000010, 1'b1, ALL, "chase_step1");
    push(e + 6, 2'd2, 6'b000010, 1'b0, ALL, "tick_one_cycle");
    press(3'b001);
    e = edges + 7;
    push(e - 1, 2'd2, 6'b001000, 1'b0, ALL, "chase_step3");
    push(e, 2'd3, 6'b111111, 1'b0, ALL, "blink_entry");
    press(3'b001);
    e = edges + 7;
    push(e - 1, 2'd3, 6'd0, 1'b0, MO, "pre_off");
    push(e, 2'd0, 6'd0, 1'b0, ALL, "wrap_off");
    push(e + 8, 2'd0, 6'd0, 1'b0, ALL, "off_hold");
    press(3'b001);

    // chase with wrap and direction change
    e = edges + 7;
    push(e, 2'd1, 6'b101010, 1'b0, ALL, "static_again");
    press(3'b001);
    c = edges + 7;
    push(c, 2'd2, 6'b000001, 1'b0, ALL, "chase_seed");
    push(c + 4, 2'd2, 6'b000001, 1'b0, ALL, "chase_before_step");
    push(c + 5, 2'd2, 6'b000010, 1'b1, ALL, "chase_shift");
    push(c + 6, 2'd2, 6'b000010, 1'b0, ALL, "chase_tick_low");
    push(c + 30, 2'd2, 6'b000001, 1'b1, ALL, "chase_wrap_left");
    push(c + 35, 2'd2, 6'b100000, 1'b1, ALL, "chase_wrap_right");
    push(c + 40, 2'd2, 6'b010000, 1'b1, ALL, "chase_right_step");
    btn = 3'b001;
    repeat (10) @(negedge clk);
    btn = 3'b000;
    wait_until(c + 26);
    btn = 3'b100;
    repeat (8) @(negedge clk);
    btn = 3'b000;

    // blink with pause / resume
    wait_until(c + 42);
    b = c + 49;
    push(b, 2'd3, 6'b111111, 1'b0, ALL, "blink_on");
    push(b + 5, 2'd3, 6'b000000, 1'b1, ALL, "blink_off");
    push(b + 10, 2'd3, 6'b111111, 1'b1, ALL, "blink_on2");
    btn = 3'b001;
    repeat (8) @(negedge clk);
    btn = 3'b000;
    wait_until(b + 6);
    push(b + 13, 2'd3, 6'b111111, 1'b0, ALL, "pause_entry");
    for (int k = 14; k < 67; k++)
      push(b + k, 2'd3, 6'b111111, 1'b0, ALL, "paused_frozen");
    push(b + 67, 2'd3, 6'b111111, 1'b0, ALL, "resume_edge");
    push(b + 68, 2'd3, 6'b111111, 1'b0, ALL, "resume_no_extra");
    push(b + 69, 2'd3, 6'b000000, 1'b1, ALL, "resume_tick");
    push(b + 70, 2'd3, 6'b000000, 1'b0, ALL, "resume_tick_low");
    push(b + 74, 2'd3, 6'b111111, 1'b1, ALL, "resume_period");
    btn = 3'b010;
    repeat (8) @(negedge clk);
    btn = 3'b000;
    wait_until(b + 60);
    btn = 3'b010;
    repeat (8) @(negedge clk);
    btn = 3'b000;

    // bounce rejection then a clean hold
    wait_until(b + 76);
    t = edges;
    len = 0;
    for (int i = 0; i < 10; i++) len += hi[i] + lo[i];
    n = t + len + 4;
    for (int k = t + 1; k <= n + 6; k++)
      push(k, 2'd3, 6'd0, 1'b0, MO, "bounce_reject");
    push(n + 7, 2'd0, 6'd0, 1'b0, ALL, "bounce_one_incr");
    push(n + 20, 2'd0, 6'd0, 1'b0, ALL, "bounce_no_second");
    for (int i = 0; i < 10; i++) begin
      btn = 3'b001;
      repeat (hi[i]) @(negedge clk);
      btn = 3'b000;
      repeat (lo[i]) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    btn = 3'b001;
    repeat (8) @(negedge clk);
    btn = 3'b000;
    repeat (14) @(negedge clk);

    // simultaneous mode + dir from chase, dir left
    e = edges + 7;
    push(e, 2'd0, 6'd0, 1'b0, ALL, "dir_press_off");
    press(3'b100);
    e = edges + 7;
    push(e, 2'd1, 6'b101010, 1'b0, ALL, "static_3");
    press(3'b001);
    e = edges + 7;
    push(e, 2'd2, 6'b000001, 1'b0, ALL, "chase_3");
    push(e + 5, 2'd2, 6'b000010, 1'b1, ALL, "chase_3_left");
    press(3'b001);
    e = edges + 7;
    push(e, 2'd3, 6'b111111, 1'b0, ALL, "simul_blink");
    press(3'b101);
    e = edges + 7;
    push(e, 2'd0, 6'd0, 1'b0, ALL, "simul_off");
    press(3'b001);
    e = edges + 7;
    push(e, 2'd1, 6'b101010, 1'b0, ALL, "simul_static");
    press(3'b001);
    e = edges + 7;
    push(e, 2'd2, 6'b000001, 1'b0, ALL, "simul_chase");
    push(e + 5, 2'd2, 6'b100000, 1'b1, ALL, "simul_dir_right");
    press(3'b001);

    // reset in the middle of a debounce
    n = edges;
    push(n + 3, 2'd2, 6'd0, 1'b0, MO, "pre_rst_chase");
    push(n + 4, 2'd0, 6'd0, 1'b0, ALL, "rst_mid");
    for (int k = 5; k <= 16; k++)
      push(n + k, 2'd0, 6'd0, 1'b0, ALL, "rst_no_event");
    btn = 3'b001;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    btn = 3'b000;
    repeat (16) @(negedge clk);

    for (int k = 0; k < 40 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
